// File: rtl/checker_fetch.sv
// Wishbone read master: copies len 32-bit words from base_adr into the checker's local RAM bank.
// One outstanding access at a time; every word is REQ (until ack) then one idle GAP cycle.
module checker_fetch #(
  parameter int MEM_AW  = 3,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       base_adr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       wbm_adr_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  input  logic              wbm_err_i,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [31:0]       mem_dat
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << MEM_AW;
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    REQ   = 3'd2,
    GAP   = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       adr_q, adr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [MEM_AW-1:0] idx_q, idx_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cyc_q, cyc_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_adr_q, mem_adr_d;
  logic [31:0]       mem_dat_q, mem_dat_d;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      cyc_q     <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      cyc_q     <= cyc_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cyc_d     = cyc_q;
    mem_we_d  = 1'b0;
    mem_adr_d = mem_adr_q;
    mem_dat_d = mem_dat_q;

    // Abort wins over everything, including an ack arriving in the same cycle.
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      cyc_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            adr_d   = {base_adr[31:2], 2'b00};
            cnt_d   = len;
            idx_d   = '0;
            busy_d  = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = FIN;
          end else if (cnt_q > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            cyc_d   = 1'b1;
            tmo_d   = '0;
            state_d = REQ;
          end
        end
        REQ: begin
          if (wbm_ack_i) begin
            cyc_d     = 1'b0;
            mem_we_d  = 1'b1;
            mem_adr_d = idx_q;
            mem_dat_d = wbm_dat_i;
            if (cnt_q == LEN_W'(1)) begin
              done_d  = 1'b1;
              state_d = FIN;
            end else begin
              adr_d   = adr_q + 32'd4;
              idx_d   = idx_q + MEM_AW'(1);
              cnt_d   = cnt_q - LEN_W'(1);
              state_d = GAP;
            end
          end else if (wbm_err_i || tmo_q == TMO_LAST) begin
            cyc_d   = 1'b0;
            err_d   = 1'b1;
            state_d = FIN;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        GAP: begin
          cyc_d   = 1'b1;
          tmo_d   = '0;
          state_d = REQ;
        end
        FIN: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: begin
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hf;
  assign mem_we    = mem_we_q;
  assign mem_adr   = mem_adr_q;
  assign mem_dat   = mem_dat_q;

endmodule

// File: tb/tb_checker_fetch.sv
// Scoreboard bench for checker_fetch: a Wishbone slave model plus a negedge monitor
// that pops expected bus addresses, RAM writes and done/err events.
module tb_checker_fetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        start, abort;
  logic [31:0] base_adr;
  logic [15:0] len;
  logic        busy, done, err;
  logic [31:0] wbm_adr_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic        mem_we;
  logic [2:0]  mem_adr;
  logic [31:0] mem_dat;

  checker_fetch #(.MEM_AW(3), .LEN_W(16), .TIMEOUT(255)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .abort(abort),
    .base_adr(base_adr), .len(len), .busy(busy), .done(done), .err(err),
    .wbm_adr_o(wbm_adr_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .mem_we(mem_we),
    .mem_adr(mem_adr), .mem_dat(mem_dat)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: output seen with nothing expected", name);
  endtask

  function automatic logic [31:0] wdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
  endfunction

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] dat;
  } wr_t;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  wr_t         exp_wr[$];
  logic [31:0] exp_bus[$];
  int          exp_evt[$];

  // Slave behaviour knobs: mode 0 = respond on stb cycle 'lat', mode 1 = never respond.
  int lat = 2;
  int mode = 0;
  int err_word = 0;
  int stb_n = 0;
  int word_no = 0;

  always @(negedge sys_clk) begin
    if (!busy) word_no = 0;
    if (!wbm_cyc_o) begin
      stb_n     = 0;
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
    end else begin
      stb_n++;
      if (stb_n == 1) word_no++;
      wbm_dat_i = wdat(wbm_adr_o);
      wbm_ack_i = (mode == 0) && (stb_n == lat) && (word_no != err_word);
      wbm_err_i = (mode == 0) && (stb_n == lat) && (word_no == err_word);
    end
  end

  logic cyc_prev = 1'b0;
  int   cyc_cnt = 0, we_cnt = 0, done_cnt = 0, err_cnt = 0, bus_seen = 0;

  always @(negedge sys_clk) begin
    wr_t e;
    int  ev;
    if (wbm_cyc_o) cyc_cnt++;
    if (wbm_cyc_o && !cyc_prev) begin
      bus_seen++;
      check("stb_with_cyc", {31'b0, wbm_stb_o}, 32'd1);
      if (exp_bus.size() == 0) unexpected("bus_adr");
      else check("bus_adr", wbm_adr_o, exp_bus.pop_front());
    end
    cyc_prev = wbm_cyc_o;
    if (mem_we) begin
      we_cnt++;
      if (exp_wr.size() == 0) unexpected("mem_we");
      else begin
        e = exp_wr.pop_front();
        check("mem_adr", {29'b0, mem_adr}, {29'b0, e.idx});
        check("mem_dat", mem_dat, e.dat);
      end
    end
    if (done && err) unexpected("done_and_err");
    if (done) begin
      done_cnt++;
      if (exp_evt.size() == 0) unexpected("done");
      else begin ev = exp_evt.pop_front(); check("evt_done", ev, EV_DONE); end
    end
    if (err) begin
      err_cnt++;
      if (exp_evt.size() == 0) unexpected("err");
      else begin ev = exp_evt.pop_front(); check("evt_err", ev, EV_ERR); end
    end
  end

  task automatic push_run(input logic [31:0] base, input int nbus, input int nwr, input int evt);
    for (int i = 0; i < nbus; i++) exp_bus.push_back(base + 32'(4 * i));
    for (int i = 0; i < nwr; i++) exp_wr.push_back({3'(i), wdat(base + 32'(4 * i))});
    if (evt != 0) exp_evt.push_back(evt);
  endtask

  task automatic start_run(input logic [31:0] base, input logic [15:0] n);
    @(posedge sys_clk); #1;
    base_adr = base;
    len      = n;
    start    = 1'b1;
    @(posedge sys_clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 2000) begin
      @(posedge sys_clk); #1;
      n++;
    end
    check({name, "_idle"}, {31'b0, busy}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_bus(input string name, input int target);
    int n = 0;
    while (bus_seen < target && n < 500) begin
      @(posedge sys_clk);
      n++;
    end
    check({name, "_reach"}, bus_seen, target);
  endtask

  task automatic drained(input string name);
    check({name, "_bus_left"}, exp_bus.size(), 0);
    check({name, "_wr_left"},  exp_wr.size(),  0);
    check({name, "_evt_left"}, exp_evt.size(), 0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_ctl"}, {25'b0, busy, done, err, wbm_cyc_o, wbm_stb_o, wbm_we_o, mem_we}, 32'd0);
    check({name, "_adr"}, wbm_adr_o, 32'd0);
    check({name, "_madr"}, {29'b0, mem_adr}, 32'd0);
    check({name, "_mdat"}, mem_dat, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, w0, d0, e0, b0;
    sys_rst = 1'b1; start = 1'b0; abort = 1'b0; base_adr = '0; len = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check_zero("reset");
    check("sel", {28'b0, wbm_sel_o}, 32'hf);
    sys_rst = 1'b0;

    // 1: four words, ack on 2nd stb cycle
    lat = 2; mode = 0; err_word = 0;
    d0 = done_cnt;
    push_run(32'h1000, 4, 4, EV_DONE);
    start_run(32'h1000, 16'd4);
    check("t1_busy", {31'b0, busy}, 32'd1);
    wait_idle("t1");
    check("t1_done_cnt", done_cnt - d0, 1);
    drained("t1");

    // 2a: len 0 finishes two cycles after start without touching the bus
    c0 = cyc_cnt;
    exp_evt.push_back(EV_DONE);
    start_run(32'h1000, 16'd0);
    check("t2a_done_c1", {31'b0, done}, 32'd0);
    @(posedge sys_clk); #1;
    check("t2a_done_c2", {31'b0, done}, 32'd1);
    @(posedge sys_clk); #1;
    check("t2a_done_c3", {31'b0, done}, 32'd0);
    check("t2a_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(posedge sys_clk);
    check("t2a_no_cyc", cyc_cnt - c0, 0);

    // 2b: len 9 exceeds the 8-word bank
    c0 = cyc_cnt; e0 = err_cnt;
    exp_evt.push_back(EV_ERR);
    start_run(32'h1000, 16'd9);
    wait_idle("t2b");
    check("t2b_no_cyc", cyc_cnt - c0, 0);
    check("t2b_err_cnt", err_cnt - e0, 1);

    // 2c: exactly 8 words, unaligned base, zero-wait slave
    lat = 1;
    push_run(32'h2004, 8, 8, EV_DONE);
    start_run(32'h2006, 16'd8);
    wait_idle("t2c");
    drained("t2c");

    // 3: bus error on the 3rd word, then a clean 2-word run
    lat = 2; err_word = 3;
    w0 = we_cnt; e0 = err_cnt;
    push_run(32'h3000, 3, 2, EV_ERR);
    start_run(32'h3000, 16'd4);
    wait_idle("t3");
    check("t3_we_cnt", we_cnt - w0, 2);
    check("t3_err_cnt", err_cnt - e0, 1);
    check("t3_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    err_word = 0;
    push_run(32'h3100, 2, 2, EV_DONE);
    start_run(32'h3100, 16'd2);
    wait_idle("t3b");
    drained("t3");

    // 4: slave never answers
    mode = 1;
    c0 = cyc_cnt; w0 = we_cnt;
    push_run(32'h4000, 1, 0, EV_ERR);
    start_run(32'h4000, 16'd2);
    wait_idle("t4");
    check("t4_cyc_cycles", cyc_cnt - c0, 255);
    check("t4_we_cnt", we_cnt - w0, 0);
    drained("t4");
    mode = 0;

    // 5: abort (with a concurrent start) while waiting on word 2
    lat = 4;
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt; b0 = bus_seen;
    push_run(32'h5000, 2, 1, 0);
    start_run(32'h5000, 16'd3);
    wait_bus("t5", b0 + 2);
    #1;
    abort = 1'b1; start = 1'b1; base_adr = 32'h7000; len = 16'd1;
    @(posedge sys_clk); #1;
    abort = 1'b0; start = 1'b0;
    check("t5_cyc", {31'b0, wbm_cyc_o}, 32'd0);
    check("t5_busy", {31'b0, busy}, 32'd0);
    repeat (5) @(posedge sys_clk);
    #1;
    check("t5_busy_later", {31'b0, busy}, 32'd0);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_no_err", err_cnt - e0, 0);
    check("t5_we_cnt", we_cnt - w0, 1);
    drained("t5");

    // 6: async reset mid-transfer, then a run that wraps the address
    lat = 2;
    b0 = bus_seen;
    push_run(32'h6000, 4, 4, EV_DONE);
    start_run(32'h6000, 16'd4);
    wait_bus("t6", b0 + 2);
    #1;
    check("t6_pre_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    sys_rst = 1'b1;
    #1;
    check_zero("t6_rst");
    @(posedge sys_clk);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    exp_bus.delete(); exp_wr.delete(); exp_evt.delete();
    push_run(32'hFFFF_FFF8, 3, 3, EV_DONE);
    start_run(32'hFFFF_FFF8, 16'd3);
    wait_idle("t6b");
    drained("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
